// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA scan path.
// Defaults describe 640x480@60; the top accepts overrides.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF = 4;

  localparam int H_DISP_DEF = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_DISP_DEF = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL =
    H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL =
    V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_DISP_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISP_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef logic [1:0] mode_t;

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate divider: one-cycle p_tick every CLK_DIV clocks.
// pre_tick announces next cycle's tick so the top can register alongside it.
module vga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_d,
  input  logic reset_n,
  input  logic run,
  output logic p_tick,
  output logic pre_tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;
  logic [W-1:0] div_nxt;

  always_comb begin
    div_nxt = '0;
    if (run && div_cnt != LAST) begin
      div_nxt = div_cnt + W'(1);
    end
    pre_tick = run && (div_nxt == LAST);
  end

  always_ff @(posedge clk_d or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      p_tick  <= pre_tick;
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: FSM, x/y scan counters, sync decode, mode latch.
// All outputs are registered from next-state values, so they never skew.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic       clk_d,
  input  logic       reset_n,
  input  logic       en,
  input  mode_t      mode_in,
  output mode_t      mode_out,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST =
    10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       run;
  logic       pre_tick;
  logic       wrap;
  logic       active;
  logic       latch;

  assign run = (state != IDLE);

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_d    (clk_d),
    .reset_n  (reset_n),
    .run      (run),
    .p_tick   (p_tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    wrap = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        // en dropping on the final tick skips DRAIN entirely
        if (!en) state_nxt = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (en) state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_nxt = pixel_x;
    y_nxt = pixel_y;
    if (state == IDLE) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (p_tick) begin
      if (pixel_x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
      end else begin
        x_nxt = pixel_x + 10'd1;
      end
    end
    active = (state_nxt != IDLE);
    latch  = ((state == IDLE) && en) || wrap;
  end

  always_ff @(posedge clk_d or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      mode_out    <= '0;
    end else begin
      state       <= state_nxt;
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      video_on    <= active && (x_nxt < H_VIS) && (y_nxt < V_VIS);
      hsync       <= !(active && x_nxt >= HS_BEG && x_nxt <= HS_END);
      vsync       <= !(active && y_nxt >= VS_BEG && y_nxt <= VS_END);
      frame_start <= active && pre_tick && x_nxt == '0 && y_nxt == '0;
      if (latch) mode_out <= mode_in;
    end
  end

endmodule
